// File: rtl/alu_issue_queue.sv
// rtl/alu_issue_queue.sv - ALU command issue queue: circular FIFO feeding a registered ALU operand stage
// Optional opcode filter enabled by defining ALU_ISSUE_OPCHK_EN.
module alu_issue_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          in_src1,
  input  logic [DATA_W-1:0]          in_src2,
  input  logic [3:0]                 in_op,
  output logic [DATA_W-1:0]          src1,
  output logic [DATA_W-1:0]          src2,
  output logic [3:0]                 ALU_control,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     fifo_count,
  output logic [7:0]                 drop_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DATA_W-1:0] r_mem_src1 [DEPTH];
  logic [DATA_W-1:0] r_mem_src2 [DEPTH];
  logic [3:0]        r_mem_op   [DEPTH];

  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;

  logic [DATA_W-1:0] r_src1;
  logic [DATA_W-1:0] r_src2;
  logic [3:0]        r_op;
  logic              r_out_valid;

  logic              w_accept;
  logic              w_legal;
  logic              w_write;
  logic              w_load;

  // Ready is a pure decode of the stored count; a full FIFO never bypasses into the output stage
  assign in_ready = (r_count != CW'(DEPTH));
  assign w_accept = in_valid && in_ready;
  assign w_write  = w_accept && w_legal;
  // Head moves to the output stage when something is stored and the stage is free or being drained
  assign w_load   = (r_count != '0) && (!r_out_valid || out_ready);

`ifdef ALU_ISSUE_OPCHK_EN
  logic [7:0] r_drop_cnt;

  // Only AND, OR, ADD, SUB, SLT and NOR are forwarded to the ALU
  always_comb begin
    w_legal = 1'b0;
    case (in_op)
      4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd12: w_legal = 1'b1;
      default:                             w_legal = 1'b0;
    endcase
  end

  // Count filtered commands, saturating so the counter never wraps back to a small value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drop_cnt <= 8'd0;
    end else if (w_accept && !w_legal && (r_drop_cnt != 8'hFF)) begin
      r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end

  assign drop_cnt = r_drop_cnt;
`else
  assign w_legal  = 1'b1;
  assign drop_cnt = 8'd0;
`endif

  // Storage array is written at the tail; contents need no reset since pointers gate visibility
  always_ff @(posedge clk) begin
    if (w_write) begin
      r_mem_src1[r_wr_ptr] <= in_src1;
      r_mem_src2[r_wr_ptr] <= in_src2;
      r_mem_op[r_wr_ptr]   <= in_op;
    end
  end

  // Pointer and occupancy bookkeeping; power-of-two depth lets pointers wrap naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_write) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_load)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_write, w_load})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Output stage: load head when possible, otherwise clear valid on a completed handshake and hold data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_src1      <= '0;
      r_src2      <= '0;
      r_op        <= '0;
      r_out_valid <= 1'b0;
    end else if (w_load) begin
      r_src1      <= r_mem_src1[r_rd_ptr];
      r_src2      <= r_mem_src2[r_rd_ptr];
      r_op        <= r_mem_op[r_rd_ptr];
      r_out_valid <= 1'b1;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign src1        = r_src1;
  assign src2        = r_src2;
  assign ALU_control = r_op;
  assign out_valid   = r_out_valid;
  assign fifo_count  = r_count;

endmodule

// File: tb/tb_alu_issue_queue.sv
// tb/tb_alu_issue_queue.sv - scoreboard bench for alu_issue_queue (DEPTH=4, DATA_W=32)
module tb_alu_issue_queue;

  localparam int DEPTH  = 4;
  localparam int DATA_W = 32;

  typedef struct packed {
    logic [31:0] s1;
    logic [31:0] s2;
    logic [3:0]  op;
  } cmd_t;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_src1;
  logic [DATA_W-1:0] in_src2;
  logic [3:0]        in_op;
  logic [DATA_W-1:0] src1;
  logic [DATA_W-1:0] src2;
  logic [3:0]        ALU_control;
  logic              out_valid;
  logic              out_ready;
  logic [2:0]        fifo_count;
  logic [7:0]        drop_cnt;

  int   n_checks = 0;
  int   n_errs   = 0;
  int   n_out    = 0;
  int   max_cnt  = 0;
  cmd_t sb[$];

  alu_issue_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_src1     (in_src1),
    .in_src2     (in_src2),
    .in_op       (in_op),
    .src1        (src1),
    .src2        (src2),
    .ALU_control (ALU_control),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .fifo_count  (fifo_count),
    .drop_cnt    (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic bit op_ok(input logic [3:0] op);
`ifdef ALU_ISSUE_OPCHK_EN
    return (op == 4'd0) || (op == 4'd1) || (op == 4'd2) ||
           (op == 4'd6) || (op == 4'd7) || (op == 4'd12);
`else
    return 1'b1;
`endif
  endfunction

  // Scoreboard: record accepted legal commands, compare at each output handshake
  always @(negedge clk) begin
    if (rst_n) begin
      if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
      if (in_valid && in_ready && op_ok(in_op))
        sb.push_back('{s1: in_src1, s2: in_src2, op: in_op});
      if (out_valid && out_ready) begin
        n_out++;
        if (sb.size() == 0) begin
          check_eq("spurious_out", 64'(sb.size()), 64'd1);
        end else begin
          cmd_t e;
          e = sb.pop_front();
          check_eq("out_src1", 64'(src1), 64'(e.s1));
          check_eq("out_src2", 64'(src2), 64'(e.s2));
          check_eq("out_op",   64'(ALU_control), 64'(e.op));
        end
      end
    end
  end

  // Offer a command (called just after a rising edge) and hold it until accepted
  task automatic send_cmd(input logic [31:0] s1, input logic [31:0] s2, input logic [3:0] op);
    bit acc;
    int n;
    in_valid = 1'b1;
    in_src1  = s1;
    in_src2  = s2;
    in_op    = op;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) check_eq("send_timeout", 64'(n), 64'd0);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while ((sb.size() != 0 || out_valid) && n < 400) begin
      @(negedge clk);
      n++;
    end
    check_eq({"drain_", tag}, 64'(n < 400), 64'd1);
    @(posedge clk);
    #1;
  endtask

  logic [3:0] legal_ops [6];
  logic [3:0] chk_ops [5];

  initial begin
    int base;
    int run;
    bit done;
    legal_ops = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd12};
    chk_ops   = '{4'd2, 4'd3, 4'd6, 4'd15, 4'd7};

    rst_n = 1'b0;
    in_valid = 1'b0;
    in_src1 = '0;
    in_src2 = '0;
    in_op = '0;
    out_ready = 1'b0;

    // Reset state
    #2;
    check_eq("rst_in_ready",   64'(in_ready), 64'd1);
    check_eq("rst_out_valid",  64'(out_valid), 64'd0);
    check_eq("rst_src1",       64'(src1), 64'd0);
    check_eq("rst_src2",       64'(src2), 64'd0);
    check_eq("rst_alu_ctrl",   64'(ALU_control), 64'd0);
    check_eq("rst_fifo_count", 64'(fifo_count), 64'd0);
    check_eq("rst_drop_cnt",   64'(drop_cnt), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single command latency, first edge after reset release
    out_ready = 1'b1;
    base = n_out;
    send_cmd(32'h0000000F, 32'h000000F0, 4'd1);
    in_valid = 1'b0;
    check_eq("single_n_valid", 64'(out_valid), 64'd0);
    check_eq("single_n_count", 64'(fifo_count), 64'd1);
    @(posedge clk);
    #1;
    check_eq("single_n1_valid", 64'(out_valid), 64'd1);
    check_eq("single_n1_src1",  64'(src1), 64'h0000000F);
    check_eq("single_n1_src2",  64'(src2), 64'h000000F0);
    check_eq("single_n1_op",    64'(ALU_control), 64'd1);
    @(posedge clk);
    #1;
    check_eq("single_n2_valid", 64'(out_valid), 64'd0);
    check_eq("single_n2_hold",  64'(src1), 64'h0000000F);
    check_eq("single_n_out",    64'(n_out - base), 64'd1);

    // Fill: output register plus DEPTH entries, then a refused sixth offer
    out_ready = 1'b0;
    base = n_out;
    for (int i = 0; i < 5; i++)
      send_cmd(32'h100 + 32'(i), 32'h200 + 32'(i), legal_ops[i % 6]);
    check_eq("fill_valid",    64'(out_valid), 64'd1);
    check_eq("fill_count",    64'(fifo_count), 64'd4);
    check_eq("fill_in_ready", 64'(in_ready), 64'd0);
    in_src1 = 32'h106;
    in_src2 = 32'h206;
    in_op   = 4'd2;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("fill_6th_ready", 64'(in_ready), 64'd0);
      check_eq("fill_6th_count", 64'(fifo_count), 64'd4);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain("fill");
    check_eq("fill_n_out", 64'(n_out - base), 64'd5);

    // Stream: one command per cycle with the consumer always ready
    base = n_out;
    max_cnt = 0;
    run = 0;
    fork
      begin
        for (int i = 0; i < 16; i++)
          send_cmd(32'(i), 32'h5A5A0000 + 32'(i), 4'd2);
        in_valid = 1'b0;
      end
      begin
        int w;
        w = 0;
        @(negedge clk);
        while (!out_valid && w < 20) begin
          @(negedge clk);
          w++;
        end
        while (out_valid && run < 40) begin
          run++;
          @(negedge clk);
        end
      end
    join
    drain("stream");
    check_eq("stream_run",     64'(run), 64'd16);
    check_eq("stream_n_out",   64'(n_out - base), 64'd16);
    check_eq("stream_max_cnt", 64'(max_cnt), 64'd1);

    // Wrap/stall: consumer toggles every cycle across pointer wrap
    base = n_out;
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 12; i++)
          send_cmd(32'hA000 + 32'(i), ~(32'hA000 + 32'(i)), legal_ops[(i + 2) % 6]);
        in_valid = 1'b0;
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          out_ready = ~out_ready;
        end
      end
    join
    out_ready = 1'b1;
    drain("wrap");
    check_eq("wrap_n_out", 64'(n_out - base), 64'd12);

    // Opcode filter behaviour
    base = n_out;
    for (int i = 0; i < 5; i++)
      send_cmd(32'hC0 + 32'(i), 32'hD0 + 32'(i), chk_ops[i]);
    in_valid = 1'b0;
    drain("opchk");
`ifdef ALU_ISSUE_OPCHK_EN
    check_eq("opchk_n_out", 64'(n_out - base), 64'd3);
    check_eq("opchk_drop",  64'(drop_cnt), 64'd2);
`else
    check_eq("opchk_n_out", 64'(n_out - base), 64'd5);
    check_eq("opchk_drop",  64'(drop_cnt), 64'd0);
`endif
    for (int i = 0; i < 300; i++)
      send_cmd(32'(i), 32'(i), 4'd3);
    in_valid = 1'b0;
    drain("opsat");
`ifdef ALU_ISSUE_OPCHK_EN
    check_eq("opsat_drop", 64'(drop_cnt), 64'd255);
`else
    check_eq("opsat_drop", 64'(drop_cnt), 64'd0);
`endif

    // Reset mid-run discards everything queued and presented
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      send_cmd(32'hE0 + 32'(i), 32'hF0 + 32'(i), 4'd0);
    in_valid = 1'b0;
    check_eq("mid_pre_count", 64'(fifo_count), 64'd3);
    check_eq("mid_pre_valid", 64'(out_valid), 64'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_valid",  64'(out_valid), 64'd0);
    check_eq("mid_rst_src1",   64'(src1), 64'd0);
    check_eq("mid_rst_src2",   64'(src2), 64'd0);
    check_eq("mid_rst_op",     64'(ALU_control), 64'd0);
    check_eq("mid_rst_count",  64'(fifo_count), 64'd0);
    check_eq("mid_rst_ready",  64'(in_ready), 64'd1);
    check_eq("mid_rst_drop",   64'(drop_cnt), 64'd0);
    sb.delete();
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    base = n_out;
    send_cmd(32'h12345678, 32'h9ABCDEF0, 4'd12);
    in_valid = 1'b0;
    drain("post_rst");
    check_eq("post_rst_n_out", 64'(n_out - base), 64'd1);
    check_eq("post_rst_src1",  64'(src1), 64'h12345678);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
